// File: rtl/led_frame_tx.sv
// Pulse-width serial encoder for the LED chain: 24-bit pixel words in over valid/ready,
// single-wire bitstream out, with a low latch period closing each frame.
module led_frame_tx #(
   parameter int T0H    = 40,
   parameter int T1H    = 80,
   parameter int TBIT   = 125,
   parameter int TRESET = 5000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [23:0] i_pix_data,
   input  logic        i_pix_valid,
   input  logic        i_pix_last,
   output logic        o_pix_ready,
   output logic        o_serial,
   output logic        o_busy,
   output logic        o_underrun
);

   localparam int CMAX = (TBIT > TRESET) ? TBIT : TRESET;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [CW-1:0] BIT_END = CW'(TBIT - 1);
   localparam logic [CW-1:0] RST_END = CW'(TRESET - 1);
   localparam logic [CW-1:0] T0H_C   = CW'(T0H);
   localparam logic [CW-1:0] T1H_C   = CW'(T1H);
   localparam logic [CW-1:0] CYC_ONE = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_HOLD,
      S_LATCH
   } state_e;

   state_e        state_q, state_d;
   logic [23:0]   shift_q, shift_d;
   logic [4:0]    bit_q, bit_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic          last_q, last_d;
   logic          serial_q, serial_d;
   logic          underrun_q, underrun_d;
   logic          out_en_q;

   logic pix_end;
   logic pix_ready;
   logic accept;

   assign pix_end = (state_q == S_SEND) && (cyc_q == BIT_END) && (bit_q == 5'd23);

   // Ready is decoded from registered state only, so it never loops back through i_pix_valid.
   always_comb begin
      pix_ready = 1'b0;
      case (state_q)
         S_IDLE:  pix_ready = out_en_q;
         S_SEND:  pix_ready = pix_end && !last_q;
         S_HOLD:  pix_ready = 1'b1;
         default: pix_ready = 1'b0;
      endcase
   end

   assign accept = pix_ready && i_pix_valid;

   // NOTE: every always_comb output gets a default first; a path that leaves one unassigned
   // would infer a latch.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_d      = bit_q;
      cyc_d      = cyc_q;
      last_d     = last_q;
      serial_d   = 1'b0;
      underrun_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_SEND;
               shift_d = i_pix_data;
               last_d  = i_pix_last;
               bit_d   = '0;
               cyc_d   = '0;
            end
         end

         S_SEND: begin
            serial_d = (cyc_q < (shift_q[23] ? T1H_C : T0H_C));
            if (cyc_q != BIT_END) begin
               cyc_d = cyc_q + CYC_ONE;
            end else if (bit_q != 5'd23) begin
               shift_d = {shift_q[22:0], 1'b0};
               bit_d   = bit_q + 5'd1;
               cyc_d   = '0;
            end else if (last_q) begin
               state_d = S_LATCH;
               cyc_d   = '0;
            end else if (accept) begin
               // Next word continues straight on with no idle cycle.
               shift_d = i_pix_data;
               last_d  = i_pix_last;
               bit_d   = '0;
               cyc_d   = '0;
            end else begin
               state_d    = S_HOLD;
               cyc_d      = '0;
               underrun_d = 1'b1;
            end
         end

         S_HOLD: begin
            if (accept) begin
               state_d = S_SEND;
               shift_d = i_pix_data;
               last_d  = i_pix_last;
               bit_d   = '0;
               cyc_d   = '0;
            end else if (cyc_q == RST_END) begin
               state_d = S_IDLE;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_q + CYC_ONE;
            end
         end

         S_LATCH: begin
            if (cyc_q == RST_END) begin
               state_d = S_IDLE;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_q + CYC_ONE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         bit_q      <= '0;
         cyc_q      <= '0;
         last_q     <= 1'b0;
         serial_q   <= 1'b0;
         underrun_q <= 1'b0;
         out_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_q      <= bit_d;
         cyc_q      <= cyc_d;
         last_q     <= last_d;
         serial_q   <= serial_d;
         underrun_q <= underrun_d;
         out_en_q   <= 1'b1;
      end
   end

   assign o_pix_ready = pix_ready;
   assign o_serial    = serial_q;
   assign o_busy      = (state_q != S_IDLE);
   assign o_underrun  = underrun_q;

endmodule

// File: tb/tb_led_frame_tx.sv
// Directed bench for led_frame_tx: a negedge monitor records serial pulse widths and rise
// times; frame-level checks compare them with hand-derived expectations.
module tb_led_frame_tx;

   localparam int T0H    = 3;
   localparam int T1H    = 7;
   localparam int TBIT   = 10;
   localparam int TRESET = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] pix_data = '0;
   logic        pix_valid = 1'b0;
   logic        pix_last = 1'b0;
   logic        pix_ready;
   logic        serial;
   logic        busy;
   logic        underrun;

   led_frame_tx #(
      .T0H   (T0H),
      .T1H   (T1H),
      .TBIT  (TBIT),
      .TRESET(TRESET)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_pix_data (pix_data),
      .i_pix_valid(pix_valid),
      .i_pix_last (pix_last),
      .o_pix_ready(pix_ready),
      .o_serial   (serial),
      .o_busy     (busy),
      .o_underrun (underrun)
   );

   always #5 clk = ~clk;

   // ---------------- monitor ----------------
   int   ncyc = 0;
   int   hi_len = 0;
   logic ser_prev = 1'b0;
   logic busy_prev = 1'b0;
   int   hi_q[$];
   int   rise_q[$];
   int   ur_cnt = 0;
   int   busy_cnt = 0;
   int   rdy_busy_cnt = 0;
   int   idle_cyc = 0;
   logic idle_rdy = 1'b0;

   always @(negedge clk) begin
      ncyc++;
      if (serial) begin
         if (!ser_prev) rise_q.push_back(ncyc);
         hi_len++;
      end else if (ser_prev) begin
         hi_q.push_back(hi_len);
         hi_len = 0;
      end
      ser_prev = serial;
      if (underrun) ur_cnt++;
      if (busy) begin
         busy_cnt++;
         if (pix_ready) rdy_busy_cnt++;
      end else if (busy_prev) begin
         idle_cyc = ncyc;
         idle_rdy = pix_ready;
      end
      busy_prev = busy;
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic idle_inputs();
      pix_valid = 1'b0;
      pix_data  = 24'h5A5A5A;
      pix_last  = 1'b1;
   endtask

   // Offers a word and returns just after the accepting edge; valid is left high.
   task automatic send(input logic [23:0] d, input logic l, input int budget, input string nm);
      bit hs;
      hs = 1'b0;
      pix_data  = d;
      pix_last  = l;
      pix_valid = 1'b1;
      for (int i = 0; i < budget && !hs; i++) begin
         @(negedge clk);
         if (pix_ready) hs = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!hs) check({nm, "_handshake_timeout"}, 0, 1);
   endtask

   task automatic wait_idle(input int budget, input string nm);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(posedge clk);
         #1;
         if (!busy) done = 1'b1;
      end
      if (!done) check({nm, "_idle_timeout"}, 0, 1);
   endtask

   task automatic check_pixel(input int base, input logic [23:0] w, input string nm);
      int errs;
      int exp_hi;
      errs = 0;
      if (hi_q.size() < base + 24) begin
         errs = 24;
      end else begin
         for (int i = 0; i < 24; i++) begin
            exp_hi = w[23-i] ? T1H : T0H;
            if (hi_q[base+i] != exp_hi) errs++;
         end
      end
      check({nm, "_bit_errors"}, errs, 0);
   endtask

   // One single-pixel frame with last=1, checked end to end.
   task automatic do_frame(input logic [23:0] d, input int ones, input string nm);
      int h0, r0, b0, u0, sum;
      h0 = hi_q.size();
      r0 = rise_q.size();
      b0 = busy_cnt;
      u0 = ur_cnt;
      send(d, 1'b1, 50, nm);
      idle_inputs();
      wait_idle(400, nm);
      repeat (2) @(posedge clk);
      #1;
      check({nm, "_pulses"}, hi_q.size() - h0, 24);
      check_pixel(h0, d, nm);
      sum = 0;
      for (int i = h0; i < hi_q.size(); i++) sum += hi_q[i];
      check({nm, "_high_sum"}, sum, 3 * 24 + 4 * ones);
      check({nm, "_busy_cycles"}, busy_cnt - b0, 260);
      if (rise_q.size() >= r0 + 24) begin
         check({nm, "_bit_span"}, rise_q[r0+23] - rise_q[r0], 230);
         check({nm, "_latch_to_ready"}, idle_cyc - rise_q[r0+23], 29);
      end else begin
         check({nm, "_rises"}, rise_q.size() - r0, 24);
      end
      check({nm, "_ready_at_idle"}, int'(idle_rdy), 1);
      check({nm, "_no_underrun"}, ur_cnt - u0, 0);
   endtask

   typedef struct {
      logic [23:0] data;
      int          ones;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int h0, r0, b0, u0, rb0;
      bit seen;

      vecs[0] = '{data: 24'hA50000, ones: 4};
      vecs[1] = '{data: 24'h000001, ones: 1};
      vecs[2] = '{data: 24'hFFFFFF, ones: 24};
      vecs[3] = '{data: 24'h800000, ones: 1};
      vecs[4] = '{data: 24'h123456, ones: 9};

      // ---- reset ----
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      check("rst_serial", int'(serial), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ready", int'(pix_ready), 0);
      check("rst_underrun", int'(underrun), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_ready", int'(pix_ready), 1);
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_serial", int'(serial), 0);

      // ---- single-pixel frames ----
      foreach (vecs[i]) do_frame(vecs[i].data, vecs[i].ones, $sformatf("frame%0d", i));

      // ---- back-to-back, valid held high ----
      h0  = hi_q.size();
      r0  = rise_q.size();
      b0  = busy_cnt;
      rb0 = rdy_busy_cnt;
      send(24'hFFFFFF, 1'b0, 50, "b2b_a");
      send(24'h000000, 1'b1, 600, "b2b_b");
      idle_inputs();
      wait_idle(600, "b2b");
      repeat (2) @(posedge clk);
      #1;
      check("b2b_pulses", hi_q.size() - h0, 48);
      check_pixel(h0, 24'hFFFFFF, "b2b_p0");
      check_pixel(h0 + 24, 24'h000000, "b2b_p1");
      check("b2b_busy_cycles", busy_cnt - b0, 500);
      check("b2b_ready_pulses", rdy_busy_cnt - rb0, 1);
      if (rise_q.size() >= r0 + 25) begin
         check("b2b_second_start", rise_q[r0+24] - rise_q[r0], 240);
         check("b2b_no_gap", rise_q[r0+24] - rise_q[r0+23], TBIT);
      end else begin
         check("b2b_rises", rise_q.size() - r0, 48);
      end

      // ---- underrun with 5 HOLD cycles ----
      h0 = hi_q.size();
      r0 = rise_q.size();
      b0 = busy_cnt;
      u0 = ur_cnt;
      send(24'h123456, 1'b0, 50, "ur_a");
      idle_inputs();
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (underrun) seen = 1'b1;
      end
      check("ur_pulse_seen", int'(seen), 1);
      check("ur_hold_ready", int'(pix_ready), 1);
      check("ur_hold_serial", int'(serial), 0);
      check("ur_hold_busy", int'(busy), 1);
      repeat (4) @(posedge clk);
      #1;
      send(24'h654321, 1'b1, 50, "ur_b");
      idle_inputs();
      wait_idle(600, "ur");
      repeat (2) @(posedge clk);
      #1;
      check("ur_pulse_cycles", ur_cnt - u0, 1);
      check("ur_pulses", hi_q.size() - h0, 48);
      check_pixel(h0, 24'h123456, "ur_p0");
      check_pixel(h0 + 24, 24'h654321, "ur_p1");
      check("ur_busy_cycles", busy_cnt - b0, 505);
      if (rise_q.size() >= r0 + 25)
         check("ur_gap", rise_q[r0+24] - rise_q[r0+23], TBIT + 5);
      else
         check("ur_rises", rise_q.size() - r0, 48);

      // ---- long underrun: HOLD times out ----
      h0 = hi_q.size();
      b0 = busy_cnt;
      u0 = ur_cnt;
      send(24'h0F0F0F, 1'b0, 50, "lu");
      idle_inputs();
      wait_idle(400, "lu");
      check("lu_busy_cycles", busy_cnt - b0, 260);
      check("lu_underrun", ur_cnt - u0, 1);
      check("lu_pulses", hi_q.size() - h0, 24);
      check_pixel(h0, 24'h0F0F0F, "lu");
      r0 = rise_q.size();
      b0 = busy_cnt;
      repeat (25) @(posedge clk);
      #1;
      check("lu_quiet_rises", rise_q.size() - r0, 0);
      check("lu_quiet_busy", busy_cnt - b0, 0);
      check("lu_ready", int'(pix_ready), 1);

      // ---- reset in the middle of bit 5 ----
      r0 = rise_q.size();
      send(24'hFFFFFF, 1'b1, 50, "mr");
      idle_inputs();
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (rise_q.size() >= r0 + 6) seen = 1'b1;
      end
      check("mr_bit5_reached", int'(seen), 1);
      check("mr_serial_high", int'(serial), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_serial_async_low", int'(serial), 0);
      check("mr_busy_low", int'(busy), 0);
      check("mr_ready_low", int'(pix_ready), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("mr_post_ready", int'(pix_ready), 1);
      check("mr_post_busy", int'(busy), 0);
      do_frame(24'h800000, 1, "mr_frame");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got 1, expected 0");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/led_frame_tx.md
# led_frame_tx

Upstream serial encoder for the LED chain. It accepts 24-bit pixel words over a valid/ready handshake and drives the single-wire, pulse-width-coded bitstream that feeds `i_serial` of the first `top_led` in the chain. Frames are terminated with a low latch period. It sits between the pixel source (frame buffer or test sequencer) and the chain input.

## Interface

- `T0H`, default 40: high-time of a `0` bit, in clock cycles.
- `T1H`, default 80: high-time of a `1` bit, in clock cycles.
- `TBIT`, default 125: total bit period, in clock cycles.
- `TRESET`, default 5000: low latch period after the last pixel of a frame, in clock cycles.
- Legal parameter values: 0 < T0H < T1H < TBIT; TRESET ≥ 1. Counter width is $clog2(max(TBIT, TRESET)+1).

- `i_clk` in 1: single clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_pix_data` in 24: pixel word, sent MSB first (bit 23 first).
- `i_pix_valid` in 1: pixel word is valid.
- `i_pix_last` in 1: marks the final pixel of a frame; qualified by `i_pix_valid`.
- `o_pix_ready` out 1: block accepts a word when `i_pix_valid` and `o_pix_ready` are both high.
- `o_serial` out 1: encoded bitstream to the chain; registered output.
- `o_busy` out 1: high in any state other than IDLE.
- `o_underrun` out 1: single-cycle pulse; a non-last pixel finished and no next word was offered.

## Operation

- States: IDLE, SEND, HOLD, LATCH.
- Datapath: 24-bit shift register, 5-bit bit counter (0..23), cycle counter, registered last-flag.
- IDLE
  - `o_pix_ready`=1, `o_serial`=0.
  - On handshake: load data and the last-flag, clear the counters, go to SEND.
- SEND
  - Cycle counter runs 0..TBIT-1 for each bit.
  - `o_serial`=1 while cyc < (current bit ? T1H : T0H); otherwise 0.
  - At cyc=TBIT-1 with bit<23: shift, increment the bit counter, cyc←0.
- End of pixel (cyc=TBIT-1, bit=23):
  - If last-flag is set: `o_pix_ready`=0, go to LATCH.
  - If last-flag is clear: `o_pix_ready`=1 in this cycle only.
    - Handshake: load the new word and stay in SEND with counters cleared. There is no gap.
    - No handshake: pulse `o_underrun`, go to HOLD.
- HOLD
  - `o_serial`=0, `o_pix_ready`=1, the cycle counter counts up.
  - Handshake: go to SEND with the new word.
  - If the counter reaches TRESET-1 with no handshake: the chain has latched; go to IDLE.
- LATCH
  - `o_serial`=0, `o_pix_ready`=0 for exactly TRESET cycles, then go to IDLE.
- `i_pix_data` and `i_pix_last` are sampled only at handshake; they may change afterwards.
- A frame of one pixel is legal (`i_pix_last` set on the first word).

## Timing

- Reset values: state=IDLE, `o_serial`=0, `o_pix_ready`=0 while `i_rst_n`=0 (1 in the first cycle after release), `o_busy`=0, `o_underrun`=0, counters and shift register = 0.
- Assertion of `i_rst_n` mid-frame forces `o_serial` low asynchronously. The partial pixel is discarded; no latch period is generated.
- Latency: handshake at edge k, so `o_serial` rises after edge k+1. Bit n occupies cycles k+1+n·TBIT … k+(n+1)·TBIT.
- Pixel duration is exactly 24·TBIT cycles. Back-to-back pixels have zero idle cycles between them.
- After the last pixel, `o_serial` is low for exactly TRESET cycles. `o_pix_ready` rises on the cycle after LATCH ends.
- `o_pix_ready` is a registered/state-decoded output. It does not depend combinationally on `i_pix_valid`.
- `o_underrun` is high for one cycle, coincident with the first HOLD cycle.

## Test plan

Test parameters: T0H=3, T1H=7, TBIT=10, TRESET=20.

- **Reset:** hold `i_rst_n`=0, then release → `o_serial`=0, `o_busy`=0; `o_pix_ready`=1 one cycle after release.
- **Single pixel:** 0xA50000 with last=1 → 24 bit periods of 10 cycles. High-times are 7,3,7,3,3,7,3,7 followed by sixteen 3s. Then 20 low cycles, then `o_pix_ready`=1. Total busy time is 260 cycles.
- **Back-to-back:** 0xFFFFFF, then 0x000000 with last=1, valid held high → ready pulses exactly once, at cycle 240 of the first pixel. The second pixel starts with no gap; total busy time is 500 cycles.
- **Underrun:** 0x123456 non-last, then valid low for 5 cycles, then 0x654321 last=1 → `o_underrun` pulses once, `o_serial` stays low 5 cycles, then the second pixel encodes correctly.
- **Long underrun:** non-last pixel, then no valid for 25 cycles → HOLD times out after 20 cycles, then IDLE with `o_busy`=0 and no further output.
- **Reset mid-pixel:** assert `i_rst_n`=0 during bit 5 while `o_serial`=1 → `o_serial` goes low immediately. After release the block is in IDLE and the next frame encodes from bit 23.
